// File: rtl/shared_mem_arbiter_pkg.sv
// Shared definitions for the shared-memory arbiter: FSM encodings and width helper.
package shared_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE   = 2'd0;
    localparam arb_state_t GRANT  = 2'd1;
    localparam arb_state_t RDWAIT = 2'd2;

    // Index width for n items, never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            r = ((32'sd1 <<< i) < n) ? (i + 1) : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/shared_mem_arbiter_if.sv
// Core-array and shared-memory bus bundle; slave is the arbiter view, master the environment view.
interface shared_mem_arbiter_if #(
    parameter int NCORES = 4,
    parameter int AW     = 32,
    parameter int DW     = 32
);
    logic [NCORES-1:0]    req;
    logic [NCORES-1:0]    rd;
    logic [NCORES-1:0]    wr;
    logic [NCORES*AW-1:0] addr;
    logic [NCORES*DW-1:0] wdata;
    logic [NCORES-1:0]    stall;
    logic [NCORES-1:0]    done;
    logic [DW-1:0]        rdata;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_rd;
    logic                 mem_wr;
    logic [DW-1:0]        mem_rdata;

    modport slave (
        input  req, rd, wr, addr, wdata, mem_rdata,
        output stall, done, rdata, mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport master (
        output req, rd, wr, addr, wdata, mem_rdata,
        input  stall, done, rdata, mem_addr, mem_wdata, mem_rd, mem_wr
    );

endinterface

// File: rtl/shared_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester found walking the ring from last_i+1.
module rr_pick
    import shared_arb_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int OW     = clog2(NCORES)
) (
    input  logic [NCORES-1:0] req_i,
    input  logic [OW-1:0]     last_i,
    output logic              valid_o,
    output logic [OW-1:0]     idx_o
);

    logic [OW-1:0] cand_s;
    logic          hit_s;

    // Ring walk; wrap is explicit so non-power-of-two core counts stay in range.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand_s  = last_i;
        hit_s   = 1'b0;
        for (int k = 0; k < NCORES; k++) begin
            cand_s  = (cand_s == OW'(NCORES - 1)) ? '0 : (cand_s + OW'(1));
            hit_s   = req_i[cand_s] & ~valid_o;
            idx_o   = hit_s ? cand_s : idx_o;
            valid_o = valid_o | hit_s;
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one memory port (1-cycle synchronous read) among NCORES stalled cores.
module shared_mem_arbiter
    import shared_arb_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    shared_mem_arbiter_if.slave  bus,
    output logic                 err
);

    localparam int            OW       = clog2(NCORES);
    localparam logic [OW-1:0] LAST_RST = OW'(NCORES - 1);

    arb_state_t        state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     last_q, last_d;
    logic              err_q, err_d;

    logic              pick_valid_s;
    logic [OW-1:0]     pick_idx_s;
    logic              mem_rd_s;
    logic              mem_wr_s;
    logic              done_en_s;
    logic [AW-1:0]     sel_addr_s;
    logic [DW-1:0]     sel_wdata_s;
    logic [NCORES-1:0] done_s;

    rr_pick #(
        .NCORES (NCORES),
        .OW     (OW)
    ) u_pick (
        .req_i   (bus.req),
        .last_i  (last_q),
        .valid_o (pick_valid_s),
        .idx_o   (pick_idx_s)
    );

    // Owner operand mux; the owner is stalled so its live inputs hold steady.
    always_comb begin
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int i = 0; i < NCORES; i++) begin
            sel_addr_s  = sel_addr_s  | (bus.addr[i*AW +: AW]  & {AW{owner_q == OW'(i)}});
            sel_wdata_s = sel_wdata_s | (bus.wdata[i*DW +: DW] & {DW{owner_q == OW'(i)}});
        end
    end

    // Arbitration FSM; every grant ends back in IDLE, so strobes never run back-to-back.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        err_d     = err_q;
        mem_rd_s  = 1'b0;
        mem_wr_s  = 1'b0;
        done_en_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    owner_d = pick_idx_s;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!bus.req[owner_q]) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end else if (bus.wr[owner_q]) begin
                    mem_wr_s  = 1'b1;
                    done_en_s = 1'b1;
                    err_d     = err_q | bus.rd[owner_q];
                    last_d    = owner_q;
                    state_d   = IDLE;
                end else if (bus.rd[owner_q]) begin
                    mem_rd_s = 1'b1;
                    state_d  = RDWAIT;
                end else begin
                    done_en_s = 1'b1;
                    err_d     = 1'b1;
                    last_d    = owner_q;
                    state_d   = IDLE;
                end
            end
            RDWAIT: begin
                done_en_s = 1'b1;
                last_d    = owner_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Completion pulse goes to the owner only.
    always_comb begin
        done_s = '0;
        for (int i = 0; i < NCORES; i++) begin
            done_s[i] = done_en_s & (owner_q == OW'(i));
        end
    end

    // State registers; reset drops everything back to IDLE so strobes fall immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LAST_RST;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign bus.stall     = bus.req & ~done_s;
    assign bus.done      = done_s;
    assign bus.mem_rd    = mem_rd_s;
    assign bus.mem_wr    = mem_wr_s;
    assign bus.mem_addr  = (state_q == GRANT)  ? sel_addr_s    : '0;
    assign bus.mem_wdata = (state_q == GRANT)  ? sel_wdata_s   : '0;
    assign bus.rdata     = (state_q == RDWAIT) ? bus.mem_rdata : '0;
    assign err           = err_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: per-cycle vector table plus hand sequences, with a done scoreboard.
module tb_shared_mem_arbiter;

    localparam int NC = 4;
    localparam int NV = 15;

    logic clk = 1'b0;
    logic reset;
    logic err;

    shared_mem_arbiter_if #(.NCORES(NC), .AW(32), .DW(32)) bus ();

    shared_mem_arbiter #(.NCORES(NC), .AW(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req, rd, wr;
        logic [3:0]  stall, done;
        logic        mrd, mwr;
        logic [31:0] maddr, mwdata, rdata;
        logic        err;
        int          push;
    } vec_t;

    typedef struct {
        int          core;
        int          kind;   // 0 write, 1 read, 2 no-op
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;

    vec_t        vecs [NV];
    sb_t         sb_q [$];
    logic [31:0] core_addr  [NC];
    logic [31:0] core_wdata [NC];
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'h1234_5678;
        else return a ^ 32'hA5A5_A5A5;
    endfunction

    function automatic vec_t mk(input logic [3:0] r, rdv, wrv, st, dn, input logic mrd, mwr,
                                input logic [31:0] ma, mw, rdat, input logic e, input int p);
        vec_t v;
        v.req = r; v.rd = rdv; v.wr = wrv; v.stall = st; v.done = dn;
        v.mrd = mrd; v.mwr = mwr; v.maddr = ma; v.mwdata = mw; v.rdata = rdat;
        v.err = e; v.push = p;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] rdv, input logic [3:0] wrv, input logic rst);
        @(negedge clk);
        reset   = rst;
        bus.req = r;
        bus.rd  = rdv;
        bus.wr  = wrv;
        #2;
    endtask

    task automatic sb_push(input int core, input int kind);
        sb_t e;
        e.core = core;
        e.kind = kind;
        e.addr = core_addr[core];
        e.data = (kind == 1) ? rom(core_addr[core]) : core_wdata[core];
        sb_q.push_back(e);
    endtask

    // Memory model: registered read, value available the cycle after mem_rd.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= rom(bus.mem_addr);
    end

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        sb_t e;
        #3;
        if (bus.done !== 4'h0) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_done", bus.done, 64'h0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_done_core", bus.done, 64'h1 << e.core);
                if (e.kind == 1) begin
                    chk("sb_rdata", bus.rdata, e.data);
                end else if (e.kind == 0) begin
                    chk("sb_mem_wr", bus.mem_wr, 64'h1);
                    chk("sb_mem_addr", bus.mem_addr, e.addr);
                    chk("sb_mem_wdata", bus.mem_wdata, e.data);
                end else begin
                    chk("sb_noop_strobes", {bus.mem_rd, bus.mem_wr}, 64'h0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        core_addr[0]  = 32'h0000_0100; core_wdata[0] = 32'hDEAD_BEEF;
        core_addr[1]  = 32'h0000_0180; core_wdata[1] = 32'h1111_1111;
        core_addr[2]  = 32'h0000_0200; core_wdata[2] = 32'h2222_2222;
        core_addr[3]  = 32'h0000_0300; core_wdata[3] = 32'h3333_3333;
        for (int i = 0; i < NC; i++) begin
            bus.addr[i*32 +: 32]  = core_addr[i];
            bus.wdata[i*32 +: 32] = core_wdata[i];
        end

        //              req   rd    wr    stall done  mrd   mwr   maddr         mwdata        rdata         err   push
        vecs[0]  = mk(4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 0);
        vecs[1]  = mk(4'hF, 4'h0, 4'hF, 4'hE, 4'h1, 1'b0, 1'b1, 32'h100,      32'hDEADBEEF, 32'h0,        1'b0, 1);
        vecs[2]  = mk(4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 2);
        vecs[3]  = mk(4'hF, 4'h0, 4'hF, 4'hD, 4'h2, 1'b0, 1'b1, 32'h180,      32'h11111111, 32'h0,        1'b0, 3);
        vecs[4]  = mk(4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 0);
        vecs[5]  = mk(4'hF, 4'h0, 4'hF, 4'hB, 4'h4, 1'b0, 1'b1, 32'h200,      32'h22222222, 32'h0,        1'b0, -1);
        vecs[6]  = mk(4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, -1);
        vecs[7]  = mk(4'hF, 4'h0, 4'hF, 4'h7, 4'h8, 1'b0, 1'b1, 32'h300,      32'h33333333, 32'h0,        1'b0, -1);
        vecs[8]  = mk(4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, -1);
        vecs[9]  = mk(4'hF, 4'h0, 4'hF, 4'hE, 4'h1, 1'b0, 1'b1, 32'h100,      32'hDEADBEEF, 32'h0,        1'b0, -1);
        vecs[10] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, -1);
        vecs[11] = mk(4'h4, 4'h4, 4'h0, 4'h4, 4'h0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 2);
        vecs[12] = mk(4'h4, 4'h4, 4'h0, 4'h4, 4'h0, 1'b1, 1'b0, 32'h200,      32'h22222222, 32'h0,        1'b0, -1);
        vecs[13] = mk(4'h4, 4'h4, 4'h0, 4'h0, 4'h4, 1'b0, 1'b0, 32'h0,        32'h0,        32'h12345678, 1'b0, -1);
        vecs[14] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, -1);

        // Reset with every core requesting.
        reset = 1'b1; bus.req = 4'hF; bus.rd = 4'h0; bus.wr = 4'hF;
        @(negedge clk); #2;
        chk("rst_stall", bus.stall, 64'hF);
        chk("rst_mem_rd", bus.mem_rd, 64'h0);
        chk("rst_mem_wr", bus.mem_wr, 64'h0);
        chk("rst_done", bus.done, 64'h0);
        chk("rst_mem_addr", bus.mem_addr, 64'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 64'h0);
        chk("rst_rdata", bus.rdata, 64'h0);
        chk("rst_err", err, 64'h0);

        // Round-robin writes from all cores, then a core 2 read.
        for (int k = 0; k < NV; k++) begin
            v = vecs[k];
            step(v.req, v.rd, v.wr, 1'b0);
            if (v.push >= 0) sb_push(v.push, v.wr[v.push] ? 0 : (v.rd[v.push] ? 1 : 2));
            chk($sformatf("v%0d_stall", k), bus.stall, v.stall);
            chk($sformatf("v%0d_done", k), bus.done, v.done);
            chk($sformatf("v%0d_mem_rd", k), bus.mem_rd, v.mrd);
            chk($sformatf("v%0d_mem_wr", k), bus.mem_wr, v.mwr);
            chk($sformatf("v%0d_err", k), err, v.err);
            if (v.mrd || v.mwr) begin
                chk($sformatf("v%0d_mem_addr", k), bus.mem_addr, v.maddr);
                chk($sformatf("v%0d_mem_wdata", k), bus.mem_wdata, v.mwdata);
            end
            if (v.rdata !== 32'h0) chk($sformatf("v%0d_rdata", k), bus.rdata, v.rdata);
        end

        // Core 1 withdraws during its grant; core 2 must win next (last=1).
        step(4'h2, 4'h0, 4'h2, 1'b0);
        chk("wd_idle_stall", bus.stall, 64'h2);
        step(4'hD, 4'h0, 4'hD, 1'b0);
        sb_push(2, 0);
        chk("wd_no_wr", bus.mem_wr, 64'h0);
        chk("wd_no_rd", bus.mem_rd, 64'h0);
        chk("wd_no_done", bus.done, 64'h0);
        step(4'hD, 4'h0, 4'hD, 1'b0);
        chk("wd_idle_done", bus.done, 64'h0);
        step(4'hD, 4'h0, 4'hD, 1'b0);
        chk("wd_next_done", bus.done, 64'h4);
        chk("wd_next_addr", bus.mem_addr, 64'h200);
        step(4'h0, 4'h0, 4'h0, 1'b0);

        // Core 3 asserts rd and wr together: write wins, err goes sticky.
        step(4'h8, 4'h8, 4'h8, 1'b0);
        sb_push(3, 0);
        step(4'h8, 4'h8, 4'h8, 1'b0);
        chk("rw_mem_wr", bus.mem_wr, 64'h1);
        chk("rw_mem_rd", bus.mem_rd, 64'h0);
        chk("rw_done", bus.done, 64'h8);
        chk("rw_err_not_yet", err, 64'h0);
        step(4'h0, 4'h0, 4'h0, 1'b0);
        chk("rw_err_set", err, 64'h1);
        repeat (10) step(4'h0, 4'h0, 4'h0, 1'b0);
        chk("rw_err_sticky", err, 64'h1);
        step(4'h0, 4'h0, 4'h0, 1'b1);
        chk("rw_err_reset", err, 64'h0);

        // Reset lands in RDWAIT for core 0; the read is dropped and redone after release.
        step(4'h1, 4'h1, 4'h0, 1'b0);
        step(4'h1, 4'h1, 4'h0, 1'b0);
        chk("mr_mem_rd", bus.mem_rd, 64'h1);
        chk("mr_mem_addr", bus.mem_addr, 64'h100);
        step(4'h1, 4'h1, 4'h0, 1'b1);
        chk("mr_rst_mem_rd", bus.mem_rd, 64'h0);
        chk("mr_rst_done", bus.done, 64'h0);
        chk("mr_rst_rdata", bus.rdata, 64'h0);
        chk("mr_rst_stall", bus.stall, 64'h1);
        step(4'h1, 4'h1, 4'h0, 1'b1);
        sb_push(0, 1);
        step(4'h1, 4'h1, 4'h0, 1'b0);
        chk("mr_idle_done", bus.done, 64'h0);
        step(4'h1, 4'h1, 4'h0, 1'b0);
        chk("mr_regrant_rd", bus.mem_rd, 64'h1);
        chk("mr_regrant_addr", bus.mem_addr, 64'h100);
        step(4'h1, 4'h1, 4'h0, 1'b0);
        chk("mr_done", bus.done, 64'h1);
        chk("mr_rdata", bus.rdata, 64'hA5A5_A4A5);
        chk("mr_stall", bus.stall, 64'h0);
        step(4'h0, 4'h0, 4'h0, 1'b0);

        // Request with neither rd nor wr: done pulse, no strobe, err set.
        step(4'h2, 4'h0, 4'h0, 1'b0);
        sb_push(1, 2);
        step(4'h2, 4'h0, 4'h0, 1'b0);
        chk("nop_done", bus.done, 64'h2);
        chk("nop_strobes", {bus.mem_rd, bus.mem_wr}, 64'h0);
        step(4'h0, 4'h0, 4'h0, 1'b0);
        chk("nop_err", err, 64'h1);
        step(4'h0, 4'h0, 4'h0, 1'b0);
        step(4'h0, 4'h0, 4'h0, 1'b0);
        chk("sb_drained", sb_q.size(), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Arbitrates the shared-memory port among NCORES single-cycle cores. Each core raises a shared-memory request flag when its access falls outside local memory.
- Grants one core at a time using round-robin order. Drives the single shared-memory port, returns read data, and holds every waiting core with a per-core stall.
- Sits between the core array and the shared data memory, which has a 1-cycle synchronous read.

Parameters:
- NCORES, 4, number of requesting cores (2..16)
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NCORES  per-core shared access request (core's sharedMEM)
- rd  in  NCORES  per-core read strobe
- wr  in  NCORES  per-core write strobe
- addr  in  NCORES*AW  packed per-core addresses; core i at [i*AW +: AW]
- wdata  in  NCORES*DW  packed per-core write data
- stall  out  NCORES  per-core hold; core must not update PC or register file while high
- done  out  NCORES  one-cycle completion pulse for core i
- rdata  out  DW  read data broadcast; valid for the core whose done bit is high
- mem_addr  out  AW  shared memory address
- mem_wdata  out  DW  shared memory write data
- mem_rd  out  1  shared memory read enable
- mem_wr  out  1  shared memory write enable
- mem_rdata  in  DW  shared memory read data, valid the cycle after mem_rd
- err  out  1  sticky protocol-error flag

Behaviour:
- State machine states: IDLE, GRANT, RDWAIT. Registers: state, owner (clog2 NCORES bits), last (last served core), err.
- Reset values (asynchronous): state=IDLE, owner=0, last=NCORES-1 so core 0 wins first, err=0. With these values mem_rd=0, mem_wr=0, done=0, and mem_addr, mem_wdata and rdata drive 0.
- stall is combinational: stall[i] = req[i] & ~done[i]. During reset, stall equals req.
- IDLE:
  - If any req is high, pick the first requester scanning last+1, last+2, ... with wrap at NCORES.
  - Load owner with that core and go to GRANT. No memory operation occurs in IDLE.
- GRANT:
  - mem_addr and mem_wdata are muxed from the owner's live inputs; these are stable because the owner is stalled.
  - If req[owner]=0 (withdrawn): no memory strobe; last=owner; go to IDLE.
  - If wr[owner]=1: mem_wr=1, done[owner]=1; last=owner; go to IDLE.
  - If wr[owner]=1 and rd[owner]=1 together: the write is performed, the read is ignored, and err is set.
  - If rd[owner] only: mem_rd=1; go to RDWAIT.
  - If req=1 but neither rd nor wr is set: set err, pulse done[owner] with no memory strobe, and go to IDLE.
- RDWAIT: rdata=mem_rdata, done[owner]=1, last=owner, go to IDLE. mem_rd=0.
- Latency, measured from req rising in cycle 0 with the arbiter in IDLE:
  - Write: done in cycle 1.
  - Read: done and data in cycle 2.
  - There is a minimum 1 idle cycle between grants, which guarantees the memory strobes are never back-to-back for different cores.
- Fairness: a core with a continuous request waits at most NCORES grants.
- Simultaneous requests resolve strictly by the round-robin pointer. Core index has no fixed priority.
- Reset mid-operation: the state returns to IDLE immediately and the strobes drop asynchronously. An in-flight read is discarded and no done is issued.
- Exactly one done bit is high at most in any cycle, and only for the owner.
- err clears only on reset.

Decomposition:
- Package shared_arb_pkg:
  - state encodings IDLE=2'd0, GRANT=2'd1, RDWAIT=2'd2
  - clog2 function for owner width
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, last index.
  - Outputs: valid, chosen index.
  - Instantiated once.

Test Plan:
1. Reset with req=4'b1111 → stall=4'b1111, mem_rd=mem_wr=0. Release reset → core 0 granted; core 0 write to addr 0x0000_0100 with data 0xDEAD_BEEF gives mem_wr=1 in cycle 1 and done=4'b0001.
2. Core 2 reads 0x0000_0200, with the memory model returning 0x1234_5678 → mem_rd=1 in cycle 1; cycle 2 gives done=4'b0100 and rdata=0x1234_5678; stall[2] drops in cycle 2.
3. All 4 cores hold writes continuously → grant order 0,1,2,3,0. Each done arrives 2 cycles apart, with no core served twice before all others are served.
4. Core 1 drops req while in GRANT → no mem strobe, no done, and the arbiter returns to IDLE. Next requester served is core 2 with last=1.
5. Core 3 asserts rd=wr=1 → write performed, err=1, err still 1 after 10 further idle cycles; reset clears it.
6. Assert reset during RDWAIT for core 0 → mem_rd=0 and done=0 immediately. After release, core 0 is re-granted first and its read completes normally.
